// File: rtl/fmrv32im_madd33_seq_if.sv
// fmrv32im_madd33_seq_if: issue/result bundle between the execute stage and the MADD33 sequencer
interface fmrv32im_madd33_seq_if;
  logic        INST_MADD33;
  logic [31:0] RS1, RS2, RS3, RS4, RS5, RS6;
  logic        WAIT;
  logic        READY;
  logic [31:0] RD;
  modport master (
    output INST_MADD33, RS1, RS2, RS3, RS4, RS5, RS6,
    input  WAIT, READY, RD
  );
  modport slave (
    input  INST_MADD33, RS1, RS2, RS3, RS4, RS5, RS6,
    output WAIT, READY, RD
  );
endinterface

// File: rtl/fmrv32im_madd33_seq.sv
// fmrv32im_madd33_seq: RD = RS1*RS2 + RS3*RS4 + RS5*RS6 stepped through one shared 32x32 multiplier
module fmrv32im_madd33_seq #(
  parameter bit PIPE_MUL = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  fmrv32im_madd33_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, FLUSH, DONE} state_t;
  state_t           state, state_nxt;
  logic [5:0][31:0] op;
  logic [31:0]      acc, prod, mul_a, mul_b, product;
  logic             issue, busy, mul_state;
  always_comb begin
    busy      = state inside {MUL0, MUL1, MUL2, FLUSH};
    mul_state = state inside {MUL0, MUL1, MUL2};
    issue     = (state == IDLE || state == DONE) && bus.INST_MADD33;
    mul_a     = state == MUL0 ? op[0] : state == MUL1 ? op[2] : op[4];
    mul_b     = state == MUL0 ? op[1] : state == MUL1 ? op[3] : op[5];
    product   = mul_a * mul_b;
    state_nxt = issue           ? MUL0 :
                state == MUL0   ? MUL1 :
                state == MUL1   ? MUL2 :
                state == MUL2   ? (PIPE_MUL ? FLUSH : DONE) :
                state == FLUSH  ? DONE : IDLE;
    bus.WAIT  = RST_N && (issue || busy);
    bus.READY = state == DONE;
    bus.RD    = bus.READY ? acc : '0;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  // with PIPE_MUL the product register lags one state, so the accumulate window shifts to MUL1..FLUSH
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op   <= '0;
      acc  <= '0;
      prod <= '0;
    end else if (issue) begin
      op  <= {bus.RS6, bus.RS5, bus.RS4, bus.RS3, bus.RS2, bus.RS1};
      acc <= '0;
    end else if (PIPE_MUL) begin
      if (mul_state) prod <= product;
      if (state inside {MUL1, MUL2, FLUSH}) acc <= acc + prod;
    end else if (mul_state) begin
      acc <= acc + product;
    end
  end
endmodule

// File: tb/tb_fmrv32im_madd33_seq.sv
// tb_fmrv32im_madd33_seq: scoreboard bench covering both multiplier pipelining options
module tb_fmrv32im_madd33_seq;
  typedef logic [31:0] ops_t [6];
  typedef struct { int at; logic [31:0] rd; } exp_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  fmrv32im_madd33_seq_if i0();
  fmrv32im_madd33_seq_if i1();
  fmrv32im_madd33_seq #(.PIPE_MUL(1'b0)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(i0));
  fmrv32im_madd33_seq #(.PIPE_MUL(1'b1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(i1));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (i0.READY) begin
      if (q0.size() == 0) chk("ready0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rd0", i0.RD, e.rd);
        chk("ready0_cycle", cyc, e.at);
      end
    end else chk("rd0_zero", i0.RD, 32'd0);
  end

  always @(negedge CLK) begin
    exp_t e;
    if (i1.READY) begin
      if (q1.size() == 0) chk("ready1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rd1", i1.RD, e.rd);
        chk("ready1_cycle", cyc, e.at);
      end
    end else chk("rd1_zero", i1.RD, 32'd0);
  end

  function automatic logic wait_of(int p);
    return p != 0 ? i1.WAIT : i0.WAIT;
  endfunction

  task automatic drive(int p, logic inst, ops_t v);
    if (p == 0) begin
      i0.INST_MADD33 = inst;
      {i0.RS1, i0.RS2, i0.RS3, i0.RS4, i0.RS5, i0.RS6} = {v[0], v[1], v[2], v[3], v[4], v[5]};
    end else begin
      i1.INST_MADD33 = inst;
      {i1.RS1, i1.RS2, i1.RS3, i1.RS4, i1.RS5, i1.RS6} = {v[0], v[1], v[2], v[3], v[4], v[5]};
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(int p, ops_t v, logic [31:0] rd);
    exp_t e;
    drive(p, 1'b1, v);
    e.at = cyc + 4 + p;
    e.rd = rd;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    #1 chk("wait_issue", {31'd0, wait_of(p)}, 32'd1);
    step();
    drive(p, 1'b0, v);
  endtask

  task automatic busy(int p);
    for (int k = 0; k < 3 + p; k++) begin
      #1 chk("wait_busy", {31'd0, wait_of(p)}, 32'd1);
      step();
    end
  endtask

  task automatic done_idle(int p);
    #1 chk("wait_done", {31'd0, wait_of(p)}, 32'd0);
    step();
  endtask

  task automatic run(int p, ops_t v, logic [31:0] rd);
    issue(p, v, rd);
    busy(p);
    done_idle(p);
  endtask

  initial begin
    ops_t z, basic, sgn, wrp, twos, iso, rv;
    z     = '{0, 0, 0, 0, 0, 0};
    basic = '{1, 2, 3, 4, 5, 6};
    sgn   = '{32'hFFFFFFFF, 5, 7, 32'hFFFFFFFD, 0, 32'h12345678};
    wrp   = '{32'h00010000, 32'h00010000, 32'h7FFFFFFF, 2, 1, 1};
    twos  = '{2, 2, 2, 2, 2, 2};
    iso   = '{3, 5, 7, 11, 13, 17};
    drive(0, 1'b1, basic);
    drive(1, 1'b0, z);
    #12;
    chk("rst_wait0", {31'd0, i0.WAIT}, 32'd0);
    chk("rst_ready0", {31'd0, i0.READY}, 32'd0);
    chk("rst_rd0", i0.RD, 32'd0);
    chk("rst_wait1", {31'd0, i1.WAIT}, 32'd0);
    drive(0, 1'b0, z);
    step();
    RST_N = 1'b1;
    step();
    step();
    run(0, basic, 32'd44);
    run(1, basic, 32'd44);
    run(0, sgn, 32'hFFFFFFE6);
    run(1, sgn, 32'hFFFFFFE6);
    run(0, wrp, 32'hFFFFFFFF);
    run(1, wrp, 32'hFFFFFFFF);
    issue(0, iso, 32'd313);
    for (int k = 0; k < 3; k++) begin
      foreach (rv[i]) rv[i] = $urandom;
      drive(0, k == 1, rv);
      #1 chk("wait_iso", {31'd0, i0.WAIT}, 32'd1);
      step();
    end
    drive(0, 1'b0, z);
    done_idle(0);
    step();
    for (int p = 0; p < 2; p++) begin
      issue(p, basic, 32'd44);
      busy(p);
      issue(p, twos, 32'd12);
      busy(p);
      done_idle(p);
    end
    issue(0, basic, 32'd44);
    step();
    #2 RST_N = 1'b0;
    #1;
    chk("abort_wait", {31'd0, i0.WAIT}, 32'd0);
    chk("abort_ready", {31'd0, i0.READY}, 32'd0);
    chk("abort_rd", i0.RD, 32'd0);
    q0.delete();
    step();
    step();
    RST_N = 1'b1;
    repeat (6) step();
    run(0, sgn, 32'hFFFFFFE6);
    repeat (3) step();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
